// File: rtl/div_unit.sv
// Multi-cycle signed restoring divider: quotient to LO, remainder to HI.
// Truncates toward zero; remainder follows the dividend's sign.
module div_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, CALC, FINISH} state_t;

  state_t           state, state_n;
  logic [CW-1:0]    counter;
  logic [WIDTH-1:0] rem_reg, quo_reg, div_mag, rem_n;
  logic [WIDTH:0]   shifted;
  logic             fits, sign_q, sign_r, err, div_zero;

  // Two's complement magnitude; the most negative value maps to itself as unsigned.
  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v);
    return v[WIDTH-1] ? WIDTH'(-v) : v;
  endfunction

  assign div_zero = (divisor == '0);

  // One restoring step on the WIDTH+1 bit shifted partial remainder.
  always_comb begin
    shifted = {rem_reg, quo_reg[WIDTH-1]};
    fits    = (shifted >= {1'b0, div_mag});
    rem_n   = fits ? WIDTH'(shifted - {1'b0, div_mag}) : shifted[WIDTH-1:0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (start) state_n = div_zero ? FINISH : CALC;
      CALC:    if (counter == LAST) state_n = FINISH;
      FINISH:  state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      counter     <= '0;
      rem_reg     <= '0;
      quo_reg     <= '0;
      div_mag     <= '0;
      sign_q      <= 1'b0;
      sign_r      <= 1'b0;
      err         <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            err <= div_zero;
            if (!div_zero) begin
              quo_reg <= magnitude(dividend);
              div_mag <= magnitude(divisor);
              sign_q  <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
              sign_r  <= dividend[WIDTH-1];
              rem_reg <= '0;
              counter <= '0;
              busy    <= 1'b1;
            end
          end
        end
        CALC: begin
          rem_reg <= rem_n;
          quo_reg <= {quo_reg[WIDTH-2:0], fits};
          counter <= counter + CW'(1);
        end
        FINISH: begin
          done <= 1'b1;
          busy <= 1'b0;
          // Divide-by-zero leaves the previous results visible.
          if (err) begin
            div_by_zero <= 1'b1;
          end else begin
            quotient  <= sign_q ? WIDTH'(-quo_reg) : quo_reg;
            remainder <= sign_r ? WIDTH'(-rem_reg) : rem_reg;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Bench for div_unit: cycle-level behavioural model compared every cycle,
// directed literal cases plus randomized divisions.
module tb_div_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] dividend, divisor;
  logic [31:0] quotient, remainder;
  logic        busy, done, div_by_zero;

  int tests = 0;
  int fails = 0;

  div_unit #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .start(start),
    .dividend(dividend), .divisor(divisor),
    .quotient(quotient), .remainder(remainder),
    .busy(busy), .done(done), .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_q(input logic [31:0] a, input logic [31:0] b);
    longint sa, sb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    return 32'(sa / sb);
  endfunction

  function automatic logic [31:0] ref_r(input logic [31:0] a, input logic [31:0] b);
    longint sa, sb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    return 32'(sa % sb);
  endfunction

  // Model: an accepted request completes 33 edges later, an error 1 edge later.
  logic        m_busy, m_done, m_dbz, p_err;
  logic [31:0] m_q, m_r, p_q, p_r;
  int          pending;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_busy <= 1'b0; m_done <= 1'b0; m_dbz <= 1'b0;
      m_q <= '0; m_r <= '0; p_q <= '0; p_r <= '0; p_err <= 1'b0;
      pending <= 0;
    end else begin
      m_done <= 1'b0;
      m_dbz  <= 1'b0;
      if (pending != 0) begin
        pending <= pending - 1;
        if (pending == 1) begin
          m_busy <= 1'b0;
          m_done <= 1'b1;
          m_dbz  <= p_err;
          if (!p_err) begin
            m_q <= p_q;
            m_r <= p_r;
          end
        end
      end else if (start) begin
        if (divisor == 32'd0) begin
          pending <= 1;
          p_err   <= 1'b1;
        end else begin
          pending <= 33;
          p_err   <= 1'b0;
          m_busy  <= 1'b1;
          p_q     <= ref_q(dividend, divisor);
          p_r     <= ref_r(dividend, divisor);
        end
      end
    end
  end

  always @(negedge clk) begin
    check("busy", 32'(busy), 32'(m_busy));
    check("done", 32'(done), 32'(m_done));
    check("div_by_zero", 32'(div_by_zero), 32'(m_dbz));
    check("quotient", quotient, m_q);
    check("remainder", remainder, m_r);
  end

  task automatic start_div(input logic [31:0] a, input logic [31:0] b);
    start    = 1'b1;
    dividend = a;
    divisor  = b;
  endtask

  // Counts edges after the start edge until done; optionally injects ignored starts.
  task automatic wait_done(input bit junk, output int n, output bit seen_busy);
    n = 0;
    seen_busy = 1'b0;
    @(posedge clk); #1;
    start    = 1'b0;
    dividend = $urandom;
    divisor  = $urandom;
    if (busy) seen_busy = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      n++;
      if (busy) seen_busy = 1'b1;
      if (done) begin
        start = 1'b0;
        return;
      end
      start = junk ? ($urandom_range(0, 5) == 0) : 1'b0;
      dividend = $urandom;
      divisor  = $urandom;
    end
    start = 1'b0;
    n = -1;
    tests++;
    fails++;
    $display("FAIL wait_done: no done within 40 cycles at %0t", $time);
  endtask

  task automatic run(input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] eq, input logic [31:0] er,
                     input bit edbz, input int elat);
    int n;
    bit sb;
    start_div(a, b);
    wait_done(1'b0, n, sb);
    check("lit_quotient", quotient, eq);
    check("lit_remainder", remainder, er);
    check("lit_div_by_zero", 32'(div_by_zero), 32'(edbz));
    check("lit_latency", 32'(n), 32'(elat));
    check("model_quotient", m_q, eq);
    check("model_remainder", m_r, er);
    if (edbz) check("busy_seen_on_error", 32'(sb), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bit sb;
    logic [31:0] a, b;
    reset = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("reset_quotient", quotient, 32'd0);
    check("reset_remainder", remainder, 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);

    run(32'd7, 32'd2, 32'd3, 32'd1, 1'b0, 33);
    @(negedge clk);
    run(32'd5, 32'd0, 32'd3, 32'd1, 1'b1, 1);
    @(negedge clk);
    run(32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 33);
    @(negedge clk);
    run(32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1, 1'b0, 33);
    @(negedge clk);
    run(32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b0, 33);
    @(negedge clk);
    run(32'h8000_0000, 32'd1, 32'h8000_0000, 32'd0, 1'b0, 33);

    // 100/7 with an ignored restart mid-flight, then a start in the done cycle.
    @(negedge clk);
    start_div(32'd100, 32'd7);
    @(posedge clk); #1; start = 1'b0;
    repeat (9) @(posedge clk);
    #1; start_div(32'd9, 32'd3);
    @(posedge clk); #1; start = 1'b0;
    n = 10;
    for (int i = 0; i < 40 && !done; i++) begin
      @(posedge clk); #1;
      n++;
    end
    check("restart_quotient", quotient, 32'd14);
    check("restart_remainder", remainder, 32'd2);
    check("restart_latency", 32'(n), 32'd33);
    run(32'd9, 32'd3, 32'd3, 32'd0, 1'b0, 33);

    // Asynchronous reset mid-division.
    @(negedge clk);
    start_div(32'd100, 32'd7);
    @(posedge clk); #1; start = 1'b0;
    repeat (14) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check("async_quotient", quotient, 32'd0);
    check("async_remainder", remainder, 32'd0);
    check("async_busy", 32'(busy), 32'd0);
    check("async_done", 32'(done), 32'd0);
    check("async_div_by_zero", 32'(div_by_zero), 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    run(32'd9, 32'd3, 32'd3, 32'd0, 1'b0, 33);

    // Randomized divisions, some back-to-back, with ignored starts while busy.
    for (int k = 0; k < 150; k++) begin
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 9))
        0: b = 32'd0;
        1: b = 32'($signed($urandom_range(0, 15)) - 8);
        2: begin a = 32'h8000_0000; b = ($urandom_range(0, 1) != 0) ? 32'hFFFF_FFFF : 32'd1; end
        3: a = 32'($urandom_range(0, 255));
        4: b = a;
        default: ;
      endcase
      if ($urandom_range(0, 1) != 0) @(negedge clk);
      start_div(a, b);
      wait_done(1'b1, n, sb);
      check("rand_latency", 32'(n), (b == 32'd0) ? 32'd1 : 32'd33);
      if (b == 32'd0) check("rand_busy_on_error", 32'(sb), 32'd0);
    end

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/div_unit.md
Name: div_unit

Overview:
- Multi-cycle signed 32-bit divider that sits downstream of the control unit.
- Started by the control unit's initDiv pulse, with A and B register values as operands.
- Produces quotient (to LO) and remainder (to HI), plus completion and divide-by-zero flags.
- The control unit waits on done, then asserts HIWrite/LOWrite, or raises the divByZero exception when div_by_zero is set.

Parameters:
- WIDTH, 32, operand/result width in bits. The iteration count equals WIDTH.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  single-cycle request, driven by the control unit's initDiv.
- dividend  input  WIDTH  A register value; signed two's complement.
- divisor  input  WIDTH  B register value; signed two's complement.
- quotient  output  WIDTH  result for LO; registered.
- remainder  output  WIDTH  result for HI; registered.
- busy  output  1  high while a division is in progress.
- done  output  1  one-cycle pulse when the result or error is valid.
- div_by_zero  output  1  high together with done when divisor was 0.

Behaviour:
- Reset, asserted asynchronously at any time including mid-operation:
  - state=IDLE, counter=0.
  - quotient=0, remainder=0, busy=0, done=0, div_by_zero=0.
  - Internal working registers cleared; any in-flight division is discarded.
- States: IDLE, CALC, FINISH.
- IDLE:
  - done=0, div_by_zero=0, busy=0.
  - At an edge with start=1 and divisor!=0 (edge E0):
    - Latch |dividend| and |divisor| as unsigned magnitudes.
    - Latch sign_q = sign(dividend) XOR sign(divisor) and sign_r = sign(dividend).
    - Clear the partial remainder; counter=0; go to CALC; busy=1.
  - At an edge with start=1 and divisor==0: go to FINISH with error flag set. Quotient and remainder keep their previous values.
  - start=0: stay in IDLE.
- CALC: one restoring-division step per edge.
  - Shift {partial_rem, quotient_reg} left by 1.
  - If shifted partial_rem >= divisor magnitude, subtract the divisor magnitude and set quotient LSB=1; else LSB=0.
  - The compare/subtract uses WIDTH+1 bits so no magnitude overflows.
  - counter increments each step. After the step at counter==WIDTH-1 (edge E32 for WIDTH=32), go to FINISH.
- FINISH, a single cycle:
  - At the next edge (E33), apply signs: quotient = sign_q ? -q : q; remainder = sign_r ? -r : r.
  - Rounding is truncation toward zero; the remainder takes the dividend's sign (MIPS DIV semantics).
  - Assert done=1 for exactly one cycle after E33; busy drops to 0 at E33; return to IDLE.
  - Error path: done=1 and div_by_zero=1 for the cycle after E1, with results unchanged.
- Latency: start sampled at E0, results and done valid after E33, i.e. 33 cycles. Divide-by-zero reports after 1 cycle.
- start while busy=1 or during FINISH: ignored, no queuing.
- start in the same cycle done is high: the unit is back in IDLE at that edge, so the new start is accepted.
- Overflow case: dividend=0x80000000, divisor=0xFFFFFFFF yields quotient=0x80000000 (wraps), remainder=0. No flag is raised.
- Magnitude of 0x80000000 is represented as unsigned 0x80000000; no truncation.
- Operand inputs need to be stable only at E0; later changes have no effect.
- quotient and remainder hold their value until the next successful completion.

Test Plan:
- Reset, then dividend=7, divisor=2, start pulse → busy for 33 cycles; done pulse at E33 with quotient=0x00000003, remainder=0x00000001, div_by_zero=0.
- dividend=-7 (0xFFFFFFF9), divisor=2 → quotient=0xFFFFFFFD, remainder=0xFFFFFFFF. dividend=7, divisor=-2 → quotient=0xFFFFFFFD, remainder=0x00000001.
- divisor=0, dividend=5 after a prior 7/2 → done and div_by_zero high one cycle after start; quotient=3 and remainder=1 unchanged; busy never asserted.
- dividend=0x80000000, divisor=0xFFFFFFFF → quotient=0x80000000, remainder=0. Also 0x80000000/1 → quotient=0x80000000, remainder=0.
- Start 100/7, re-pulse start with 9/3 at cycle 10 → ignored; completion gives quotient=14, remainder=2 at E33. A back-to-back start in the done cycle is accepted.
- Assert reset at cycle 15 of a division → all outputs 0 immediately (asynchronous), state IDLE; a following 9/3 completes with quotient=3, remainder=0.
